// File: rtl/legv8_pkg.sv
// legv8_pkg: shared widths, constants and bundle types
// for the LegV8 pipeline stages.
package legv8_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 64;

   localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT =
      32'hD600_03E0;

   typedef enum logic {
      FS_RUN,
      FS_HALT
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } if_id_t;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// ifid_reg: IF/ID output register with valid/ready
// hold and flush.
module ifid_reg
   import legv8_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   flush,
   input  logic   load,
   input  if_id_t load_data,
   input  logic   out_ready,
   output logic   out_valid,
   output if_id_t out_data
);

   // flush wins over load; payload holds unless a new word lands
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, run/halt FSM and ROM addressing for
// the LegV8 fetch stage.
module fetch_unit
   import legv8_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = 64'd0,
   parameter int                 ADDR_W    = 16,
   parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic               halted
);

   logic [PC_W-1:0] pc_q;
   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic            advance;
   logic            capture;
   logic            hit;
   if_id_t          cap;
   if_id_t          ifid_q;

   assign advance  = !out_valid || out_ready;
   assign hit      = (rom_data == HALT_WORD);
   assign capture  = (state_q == FS_RUN) && advance
                     && !redirect;
   assign rom_addr = pc_q[ADDR_W-1:0];
   assign halted   = (state_q == FS_HALT);
   assign cap      = '{instr: rom_data, pc: pc_q};

   // PC: redirect target, else step past each non-halt capture
   always_ff @(posedge clock) begin
      if (reset)
         pc_q <= RESET_PC;
      else if (redirect)
         pc_q <= redirect_pc;
      else if (capture && !hit)
         pc_q <= pc_q + 64'd1;
   end

   // run/halt state register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= FS_RUN;
      else
         state_q <= state_d;
   end

   // next state: redirect restarts, capturing the halt word stops
   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         redirect:        state_d = FS_RUN;
         (capture && hit): state_d = FS_HALT;
         default:         state_d = state_q;
      endcase
   end

   ifid_reg u_ifid (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .load      (capture),
      .load_data (cap),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (ifid_q)
   );

   assign out_instr = ifid_q.instr;
   assign out_pc    = ifid_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus a
// randomized run against a behavioural fetch model.
module tb_fetch_unit;

   localparam logic [31:0] HALT = 32'hD600_03E0;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clock;
   logic        reset;
   logic [15:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        halted;

   logic [15:0] rom_addr2;
   logic [31:0] rom_data2;
   logic        out_valid2;
   logic [31:0] out_instr2;
   logic [63:0] out_pc2;
   logic        halted2;

   logic [31:0] rom_mem [65536];

   int checks;
   int errors;

   // behavioural model state
   logic [63:0] m_pc;
   logic        m_v;
   logic [31:0] m_i;
   logic [63:0] m_p;
   logic        m_h;

   assign rom_data  = rom_mem[rom_addr];
   assign rom_data2 = rom_mem[rom_addr2];

   fetch_unit u_dut (
      .clock       (clock),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .halted      (halted)
   );

   fetch_unit #(.RESET_PC(64'h20)) u_dut20 (
      .clock       (clock),
      .reset       (reset),
      .rom_addr    (rom_addr2),
      .rom_data    (rom_data2),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid2),
      .out_ready   (out_ready),
      .out_instr   (out_instr2),
      .out_pc      (out_pc2),
      .halted      (halted2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void model_step();
      logic [31:0] w;
      if (reset) begin
         m_pc = 64'd0;
         m_v  = 1'b0;
         m_i  = 32'd0;
         m_p  = 64'd0;
         m_h  = 1'b0;
      end else if (redirect) begin
         m_pc = redirect_pc;
         m_v  = 1'b0;
         m_h  = 1'b0;
      end else if (!m_h) begin
         if (!m_v || out_ready) begin
            w   = rom_mem[m_pc[15:0]];
            m_i = w;
            m_p = m_pc;
            m_v = 1'b1;
            if (w == HALT) m_h = 1'b1;
            else m_pc = m_pc + 64'd1;
         end
      end else if (m_v && out_ready) begin
         m_v = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; out_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 64'd0;
      tick(); tick();
      checks += 5;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b exp 0", out_valid);
      end
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_halted got %b exp 0", halted);
      end
      if (rom_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_addr got %h exp 0", rom_addr);
      end
      if (out_pc !== 64'd0 || out_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_out got %h/%h exp 0/0",
                  out_pc, out_instr);
      end
      if (rom_addr2 !== 16'h0020) begin
         errors++;
         $display("FAIL reset_pc20 got %h exp 0020", rom_addr2);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      for (int n = 0; n <= 4; n++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(n)
             || out_instr !== rom_mem[n]) begin
            errors++;
            $display("FAIL stream_%0d got v%b %h/%h exp v1 %h/%h",
                     n, out_valid, out_pc, out_instr,
                     64'(n), rom_mem[n]);
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'd4
             || out_instr !== rom_mem[4] || rom_addr !== 16'd5) begin
            errors++;
            $display("FAIL stall_%0d got v%b %h/%h a%h exp v1 4/%h a5",
                     k, out_valid, out_pc, out_instr, rom_addr,
                     rom_mem[4]);
         end
      end
      out_ready = 1'b1;
      for (int n = 5; n <= 9; n++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(n)
             || out_instr !== rom_mem[n]) begin
            errors++;
            $display("FAIL resume_%0d got v%b %h/%h exp v1 %h/%h",
                     n, out_valid, out_pc, out_instr,
                     64'(n), rom_mem[n]);
         end
      end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_pc = 64'd2; out_ready = 1'b0;
      tick();
      redirect = 1'b0; out_ready = 1'b1;
      checks += 2;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_bubble got v%b exp v0", out_valid);
      end
      if (rom_addr !== 16'd2) begin
         errors++;
         $display("FAIL redir_addr got %h exp 2", rom_addr);
      end
      for (int n = 2; n <= 9; n++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(n)
             || out_instr !== rom_mem[n]) begin
            errors++;
            $display("FAIL redir_%0d got v%b %h/%h exp v1 %h/%h",
                     n, out_valid, out_pc, out_instr,
                     64'(n), rom_mem[n]);
         end
      end
   endtask

   task automatic test_halt();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd10
          || out_instr !== HALT || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_cap got v%b %h/%h h%b exp v1 a/%h h1",
                  out_valid, out_pc, out_instr, halted, HALT);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== HALT
             || out_pc !== 64'd10) begin
            errors++;
            $display("FAIL halt_hold got v%b %h/%h exp v1 a/%h",
                     out_valid, out_pc, out_instr, HALT);
         end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || rom_addr !== 16'd10
             || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_idle got v%b a%h h%b exp v0 a000a h1",
                     out_valid, rom_addr, halted);
         end
      end
      redirect = 1'b1; redirect_pc = 64'd0;
      tick();
      redirect = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0
          || rom_addr !== 16'd0) begin
         errors++;
         $display("FAIL halt_restart got h%b v%b a%h exp h0 v0 a0",
                  halted, out_valid, rom_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0
          || out_instr !== rom_mem[0]) begin
         errors++;
         $display("FAIL halt_refetch got v%b %h/%h exp v1 0/%h",
                  out_valid, out_pc, out_instr, rom_mem[0]);
      end
   endtask

   task automatic test_reset_mid();
      for (int n = 1; n <= 6; n++) tick();
      out_ready = 1'b0;
      tick();
      checks++;
      if (out_pc !== 64'd6 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup got v%b %h exp v1 6",
                  out_valid, out_pc);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks += 2;
      if (out_valid !== 1'b0 || rom_addr !== 16'd0
          || halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got v%b a%h h%b exp v0 a0 h0",
                  out_valid, rom_addr, halted);
      end
      if (out_valid2 !== 1'b0 || rom_addr2 !== 16'h0020) begin
         errors++;
         $display("FAIL mid_reset20 got v%b a%h exp v0 a0020",
                  out_valid2, rom_addr2);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0) begin
         errors++;
         $display("FAIL mid_restart got v%b %h exp v1 0",
                  out_valid, out_pc);
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = ONES;
      tick();
      redirect = 1'b0;
      checks++;
      if (rom_addr !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_addr got %h exp ffff", rom_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== ONES
          || out_instr !== rom_mem[16'hFFFF]) begin
         errors++;
         $display("FAIL wrap_top got v%b %h/%h exp v1 %h/%h",
                  out_valid, out_pc, out_instr,
                  ONES, rom_mem[16'hFFFF]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'd0
          || out_instr !== rom_mem[0]) begin
         errors++;
         $display("FAIL wrap_zero got v%b %h/%h exp v1 0/%h",
                  out_valid, out_pc, out_instr, rom_mem[0]);
      end
   endtask

   task automatic test_random();
      logic        h_v;
      logic        h_r;
      logic [31:0] h_i;
      logic [63:0] h_p;
      reset = 1'b1; redirect = 1'b0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         redirect  = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0)
            redirect_pc = ONES - 64'($urandom_range(0, 3));
         else
            redirect_pc = 64'($urandom_range(0, 20));
         h_v = out_valid; h_r = out_ready;
         h_i = out_instr; h_p = out_pc;
         tick();
         checks++;
         if (out_valid !== m_v || halted !== m_h
             || rom_addr !== m_pc[15:0]) begin
            errors++;
            $display("FAIL rnd_ctl c%0d got v%b h%b a%h exp v%b h%b a%h",
                     c, out_valid, halted, rom_addr,
                     m_v, m_h, m_pc[15:0]);
         end
         if (m_v) begin
            checks++;
            if (out_pc !== m_p || out_instr !== m_i) begin
               errors++;
               $display("FAIL rnd_data c%0d got %h/%h exp %h/%h",
                        c, out_pc, out_instr, m_p, m_i);
            end
         end
         if (h_v && !h_r && out_valid) begin
            checks++;
            if (out_pc !== h_p || out_instr !== h_i) begin
               errors++;
               $display("FAIL rnd_hold c%0d got %h/%h exp %h/%h",
                        c, out_pc, out_instr, h_p, h_i);
            end
         end
      end
      reset = 1'b0; redirect = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int a = 0; a < 65536; a++) begin
         rom_mem[a] = $urandom;
         if (rom_mem[a] == HALT) rom_mem[a] = HALT ^ 32'd1;
      end
      rom_mem[10] = HALT;
      reset = 1'b1; redirect = 1'b0;
      redirect_pc = 64'd0; out_ready = 1'b1;
      m_pc = 64'd0; m_v = 1'b0; m_i = 32'd0;
      m_p = 64'd0; m_h = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LegV8 64-bit datapath. Holds the program counter, drives the word address into the instruction ROM, and captures each returned 32-bit instruction with its PC into an IF/ID output register. It handles a ready/valid handshake toward decode, branch redirects from execute, and a halt state entered on fetching the halt word (`BR XZR`, 0xD60003E0). The PC counts in instruction words, so ROM address *n* holds instruction *n*.

## Interface
- `RESET_PC`, 64'd0, PC value loaded on reset.
- `ADDR_W`, 16, ROM address width.
- `HALT_WORD`, 32'hD60003E0, instruction that sends the fetch unit to HALT.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `rom_addr` output ADDR_W: word address to the ROM, always equal to `pc[ADDR_W-1:0]`.
- `rom_data` input 32: instruction from the ROM, combinational from `rom_addr`.
- `redirect` input 1: branch taken or jump resolved downstream.
- `redirect_pc` input 64: word-granular target PC.
- `out_valid` output 1: the IF/ID register holds a live instruction.
- `out_ready` input 1: decode accepts this cycle.
- `out_instr` output 32: registered instruction.
- `out_pc` output 64: PC of `out_instr`.
- `halted` output 1: the unit is in HALT.

## Operation
- Internal state: `pc` (64 b) and a two-state FSM, RUN and HALT.
- `advance = !out_valid || out_ready`.
- Each edge is resolved in this priority order:
  1. **reset:** `pc ← RESET_PC`, `out_valid ← 0`, `out_instr ← 0`, `out_pc ← 0`, FSM ← RUN.
  2. **redirect** (any state):
     - `pc ← redirect_pc` and `out_valid ← 0`. This flushes the held instruction, whether or not it was being accepted.
     - FSM ← RUN.
     - No ROM word is captured that cycle.
  3. **RUN and advance:**
     - `out_instr ← rom_data`, `out_pc ← pc`, `out_valid ← 1`.
     - `pc ← pc + 1`, wrapping modulo 2^64.
     - If `rom_data == HALT_WORD`, FSM ← HALT and `pc` is not incremented.
  4. **RUN and not advance (stall):** all state holds.
  5. **HALT:**
     - No new capture.
     - If `out_valid && out_ready`, then `out_valid ← 0`. Otherwise hold.
     - `pc` holds.
- `halted = (FSM == HALT)`, a registered state decode.
- `rom_addr` truncates `pc`. Upper PC bits are not checked; out-of-range addresses return whatever the ROM supplies.

## Timing
- The ROM is combinational. Fetch latency from a PC value to `out_valid` is one edge.
- Sustained throughput is 1 instruction/cycle while `out_ready` is high.
- Redirect penalty: the instruction at `redirect_pc` is valid on `out_*` two edges after `redirect` is sampled. There is exactly one bubble cycle with `out_valid = 0`.
- A redirect in the same cycle as an accepted handshake is legal. The accepted instruction counts as consumed, and the flush only affects state thereafter.
- Outputs `out_*` are stable while `out_valid && !out_ready`. This is a ready/valid hold rule; a bench must flag any change.
- The halt word itself is delivered to decode with `out_valid = 1`. Fetch stops after it is captured.
- Reset mid-stall or mid-HALT takes effect on the same edge and discards the held instruction.

## Structure
- Shared package `legv8_pkg` holds:
  - `HALT_WORD` default.
  - `INSTR_W = 32`.
  - `PC_W = 64`.
  - FSM state enum `fetch_state_t {FS_RUN, FS_HALT}`.
- One natural sub-module, `ifid_reg`: the output register with valid/ready hold and flush logic.
- PC arithmetic and the FSM stay in `fetch_unit`.

## Test plan
- **Reset then streaming:** the ROM holds words W0..W9, `out_ready` stays 1. `out_pc` steps 0,1,2… one per cycle from the first edge after reset, with `out_instr = Wn`.
- **Backpressure:** drop `out_ready` for 3 cycles while `out_pc = 4`. `out_pc`, `out_instr` and `pc` hold for those 3 cycles. After `out_ready` returns, the next `out_pc` is 5, with no skipped or duplicated instruction.
- **Redirect:** at `out_pc = 9` assert `redirect` with `redirect_pc = 2`. The next cycle shows `out_valid = 0`, the following cycle shows `out_pc = 2`. A simultaneous stall must not suppress the flush.
- **Halt:** the ROM returns 0xD60003E0 at address 10.
  - `out_instr = 0xD60003E0` is presented once.
  - `halted` rises on the same edge.
  - After acceptance, `out_valid` stays 0 indefinitely and `rom_addr` holds 10.
  - Then `redirect_pc = 0` restarts fetch at 0 and clears `halted`.
- **Reset mid-operation:** assert `reset` while stalled at `out_pc = 6`. The next edge gives `out_valid = 0` and `pc = RESET_PC`. With `RESET_PC = 64'h20` overridden, `rom_addr` becomes 16'h0020.
- **Wrap:** redirect to 64'hFFFF_FFFF_FFFF_FFFF. The next capture has that `out_pc` and `rom_addr = 16'hFFFF`, and the following capture has `out_pc = 0`.
